instr_issue: RTL and testbench

INSTR_ISSUE -- requirements
Module: instr_issue

---
 rtl/instr_issue.sv | 99 +++++++++
 tb/tb_instr_issue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instr_issue.sv
// instr_issue: 4-entry instruction queue between the fetch/decode producer
// and the ALU stage. Holds {OP,A,B}, drops the unused opcode 3'b111 on entry,
// presents a zeroed head when empty and counts issued instructions.
module instr_issue #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  input  logic [2:0] IN_OP,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  output logic       IN_READY,
  input  logic       OUT_READY,
  input  logic       FLUSH,
  output logic       OUT_VALID,
  output logic [2:0] OP,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [2:0] COUNT,
  output logic [7:0] ISSUED
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [2:0] OP_UNUSED = 3'b111;

  logic [18:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [2:0]       r_count;
  logic [7:0]       r_issued;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [18:0]      w_head;

  // Handshake qualifiers; ready/valid come from registered occupancy only.
  always_comb begin
    w_in_ready  = (r_count != 3'(DEPTH));
    w_out_valid = (r_count != 3'd0);
    // Opcode 111 completes the handshake but never occupies an entry.
    w_push      = IN_VALID && w_in_ready && !FLUSH && (IN_OP != OP_UNUSED);
    w_pop       = w_out_valid && OUT_READY && !FLUSH;
    w_head      = r_mem[r_rptr];
  end

  // Storage write; contents are don't-care after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {IN_OP, IN_A, IN_B};
    end
  end

  // Pointers, occupancy and issue counter; reset beats flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= 3'd0;
      r_issued <= 8'h00;
    end else if (FLUSH) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 3'd0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr   <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        r_issued <= r_issued + 8'h01;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation: zeros whenever the queue is empty.
  always_comb begin
    IN_READY  = w_in_ready;
    OUT_VALID = w_out_valid;
    COUNT     = r_count;
    ISSUED    = r_issued;
    OP        = 3'b000;
    A         = 8'h00;
    B         = 8'h00;
    if (w_out_valid) begin
      OP = w_head[18:16];
      A  = w_head[15:8];
      B  = w_head[7:0];
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the instruction queue.
module tb_instr_issue;

  logic       CLK;
  logic       RST_N;
  logic       IN_VALID;
  logic [2:0] IN_OP;
  logic [7:0] IN_A;
  logic [7:0] IN_B;
  logic       IN_READY;
  logic       OUT_READY;
  logic       FLUSH;
  logic       OUT_VALID;
  logic [2:0] OP;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] COUNT;
  logic [7:0] ISSUED;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [18:0] m_q [$];
  int          m_issued;

  instr_issue #(.DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_OP(IN_OP),
    .IN_A(IN_A), .IN_B(IN_B), .IN_READY(IN_READY), .OUT_READY(OUT_READY),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OP(OP), .A(A), .B(B),
    .COUNT(COUNT), .ISSUED(ISSUED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model
  task automatic check_model(input string tag);
    logic [18:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 19'h0;
    chk({tag, ".count"},     32'(COUNT),     32'(m_q.size()));
    chk({tag, ".in_ready"},  32'(IN_READY),  32'(m_q.size() != 4));
    chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'(m_q.size() != 0));
    chk({tag, ".op"},        32'(OP),        32'(h[18:16]));
    chk({tag, ".a"},         32'(A),         32'(h[15:8]));
    chk({tag, ".b"},         32'(B),         32'(h[7:0]));
    chk({tag, ".issued"},    32'(ISSUED),    32'(m_issued % 256));
  endtask

  // Drive one cycle, advance the model by the queue rules, then compare
  task automatic cycle(input string tag, input logic rn, input logic iv,
                       input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ordy, input logic fl);
    bit can_push;
    bit do_pop;
    RST_N = rn; IN_VALID = iv; IN_OP = op; IN_A = a; IN_B = b;
    OUT_READY = ordy; FLUSH = fl;
    @(posedge CLK);
    if (!rn) begin
      m_q.delete();
      m_issued = 0;
    end else if (fl) begin
      m_q.delete();
    end else begin
      can_push = iv && (m_q.size() < 4) && (op != 3'b111);
      do_pop   = ordy && (m_q.size() > 0);
      if (do_pop) begin
        void'(m_q.pop_front());
        m_issued++;
      end
      if (can_push) m_q.push_back({op, a, b});
    end
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    cycle("rst", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_issued = 0;
    RST_N = 1'b0; IN_VALID = 1'b0; IN_OP = 3'd0; IN_A = 8'h00; IN_B = 8'h00;
    OUT_READY = 1'b0; FLUSH = 1'b0;

    // Reset state, with pending push/pop/flush requests that reset must override
    cycle("rst0", 1'b0, 1'b1, 3'd2, 8'h11, 8'h22, 1'b1, 1'b1);
    cycle("rst1", 1'b0, 1'b1, 3'd3, 8'h33, 8'h44, 1'b1, 1'b0);
    chk("reset_count", 32'(COUNT), 32'd0);
    chk("reset_in_ready", 32'(IN_READY), 32'd1);
    chk("reset_op", 32'(OP), 32'd0);

    // Fill then drain
    for (int i = 0; i < 4; i++)
      cycle("fill", 1'b1, 1'b1, 3'(i), 8'(8'h10 + i), 8'(8'h20 + i), 1'b0, 1'b0);
    chk("fill_count", 32'(COUNT), 32'd4);
    chk("fill_in_ready", 32'(IN_READY), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_op", 32'(OP), 32'(i));
      cycle("drain", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_issued", 32'(ISSUED), 32'd4);
    chk("drain_out_valid", 32'(OUT_VALID), 32'd0);

    // Full with simultaneous pop: pop happens, push refused
    for (int i = 0; i < 4; i++)
      cycle("refill", 1'b1, 1'b1, 3'(i + 1), 8'(i), 8'(i), 1'b0, 1'b0);
    cycle("fullpop", 1'b1, 1'b1, 3'd6, 8'hEE, 8'hEE, 1'b1, 1'b0);
    chk("fullpop_count", 32'(COUNT), 32'd3);
    chk("fullpop_issued", 32'(ISSUED), 32'd5);

    // Flush with push and pop requested: both ignored, ISSUED kept
    cycle("flush", 1'b1, 1'b1, 3'd4, 8'h55, 8'h66, 1'b1, 1'b1);
    chk("flush_count", 32'(COUNT), 32'd0);
    chk("flush_out_valid", 32'(OUT_VALID), 32'd0);
    chk("flush_issued", 32'(ISSUED), 32'd5);

    // Opcode 111 accepted but dropped
    do_reset();
    cycle("op111", 1'b1, 1'b1, 3'b101, 8'h01, 8'h02, 1'b0, 1'b0);
    cycle("op111", 1'b1, 1'b1, 3'b111, 8'h03, 8'h04, 1'b0, 1'b0);
    cycle("op111", 1'b1, 1'b1, 3'b110, 8'h05, 8'h06, 1'b0, 1'b0);
    chk("op111_count", 32'(COUNT), 32'd2);
    chk("op111_head", 32'(OP), 32'b101);
    cycle("op111d", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("op111_second", 32'(OP), 32'b110);
    cycle("op111d", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("op111_issued", 32'(ISSUED), 32'd2);

    // Steady stream: A out lags by one, COUNT stays 1, ISSUED wraps past FF
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      cycle("stream", 1'b1, 1'b1, 3'(i % 7), 8'(i), 8'(~i), 1'b1, 1'b0);
      if (i == 2 || i == 7 || i == 300) begin
        chk("stream_a", 32'(A), 32'(i % 256));
        chk("stream_count", 32'(COUNT), 32'd1);
      end
    end
    chk("stream_issued_wrap", 32'(ISSUED), 32'd43);

    // Mid-operation reset at COUNT=2
    cycle("mid", 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle("mid", 1'b1, 1'b1, 3'd3, 8'hA1, 8'hB1, 1'b0, 1'b0);
    cycle("mid", 1'b1, 1'b1, 3'd4, 8'hA2, 8'hB2, 1'b0, 1'b0);
    chk("mid_pre_count", 32'(COUNT), 32'd2);
    cycle("midrst", 1'b0, 1'b1, 3'd5, 8'hA3, 8'hB3, 1'b1, 1'b0);
    chk("midrst_count", 32'(COUNT), 32'd0);
    chk("midrst_issued", 32'(ISSUED), 32'd0);
    chk("midrst_in_ready", 32'(IN_READY), 32'd1);
    chk("midrst_op", 32'(OP), 32'd0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            ($urandom_range(0, 199) != 0),
            ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            8'($urandom),
            8'($urandom),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
